multicycle_ctrl_fsm: RTL and testbench

// - Main Moore FSM of the multicycle ARM controller. Sequences the shared datapath
//   (one memory, one ALU, IR) through fetch/decode/execute/memory/writeback.
// - Issues raw RegW/MemW/NextPC/Branch enables to the downstream condition-gating

---
 rtl/mc_ctrl_pkg.sv | 66 ++++++
 rtl/multicycle_ctrl_fsm_if.sv | 53 +++++
 rtl/mc_state_decode.sv | 65 ++++++
 rtl/multicycle_ctrl_fsm.sv | 160 ++++++++++++++++
 tb/tb_multicycle_ctrl_fsm.sv | 328 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared types and constants for the multicycle ARM main controller.
//   state_t      : the ten controller states
//   ADR_*/SRCA_*/SRCB_*/RES_* : datapath selector encodings
//   OP_*         : instr[27:26] major opcode classes
//   ctrl_word_t  : Moore control word produced for each state
//   wait_cnt_width() : width of the memory wait counter for a given limit
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9
    } state_t;

    // Memory address source
    localparam logic ADR_PC     = 1'b0;
    localparam logic ADR_ALURES = 1'b1;

    // ALU operand A source
    localparam logic SRCA_RD1 = 1'b0;
    localparam logic SRCA_PC  = 1'b1;

    // ALU operand B source
    localparam logic [1:0] SRCB_RD2    = 2'b00;
    localparam logic [1:0] SRCB_EXTIMM = 2'b01;
    localparam logic [1:0] SRCB_FOUR   = 2'b10;

    // Result bus source
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;

    // Major opcode classes
    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    // Raw per-state control word. fetch_load marks the state in which IR load
    // and PC+4 happen; the FSM qualifies it with mem_ready.
    typedef struct packed {
        logic       mem_req;
        logic       fetch_load;
        logic       branch;
        logic       reg_w;
        logic       mem_w;
        logic       adr_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] result_src;
        logic       alu_op;
    } ctrl_word_t;

    // Counter must hold values up to the limit; a limit of 0 or 1 still gets
    // one bit so the vector is never empty.
    function automatic int wait_cnt_width(input int limit);
        return (limit < 2) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/multicycle_ctrl_fsm_if.sv
// Bus between the main controller and the datapath / memory side.
// Parameter CNT_W: width of instr_count (must match the controller's CNT_W).
// Modports:
//   master : the controller (reads op/funct/mem_ready, drives controls)
//   slave  : datapath and memory (drives op/funct/mem_ready, reads controls)
//
// Memory handshake: mem_req is the request ("valid") and mem_ready the
// completion ("ready"). An access is in flight in every cycle mem_req is high
// and completes in the cycle where mem_ready is sampled high together with
// mem_req; mem_ready while mem_req is low carries no meaning. mem_req stays
// high until completion, a wait-limit abort, or reset.
//
// state is a debug view of the controller state register.
interface multicycle_ctrl_fsm_if #(
    parameter int CNT_W = 32
);
    import mc_ctrl_pkg::*;

    logic [1:0]       op;
    logic [5:0]       funct;
    logic             mem_ready;

    logic             mem_req;
    logic             ir_write;
    logic             next_pc;
    logic             branch;
    logic             reg_w;
    logic             mem_w;
    logic             adr_src;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic [1:0]       result_src;
    logic             alu_op;
    logic             illegal_op;
    logic             mem_timeout;
    logic [CNT_W-1:0] instr_count;
    state_t           state;

    modport master (
        input  op, funct, mem_ready,
        output mem_req, ir_write, next_pc, branch, reg_w, mem_w,
               adr_src, alu_src_a, alu_src_b, result_src, alu_op,
               illegal_op, mem_timeout, instr_count, state
    );

    modport slave (
        output op, funct, mem_ready,
        input  mem_req, ir_write, next_pc, branch, reg_w, mem_w,
               adr_src, alu_src_a, alu_src_b, result_src, alu_op,
               illegal_op, mem_timeout, instr_count, state
    );

endinterface

// File: rtl/mc_state_decode.sv
// Combinational map from controller state to the raw Moore control word.
// Ports:
//   state : current controller state
//   ctrl  : control word for that state (unlisted fields are 0)
module mc_state_decode
    import mc_ctrl_pkg::*;
(
    input  state_t     state,
    output ctrl_word_t ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            FETCH: begin
                ctrl.mem_req    = 1'b1;
                ctrl.fetch_load = 1'b1;
                ctrl.adr_src    = ADR_PC;
                ctrl.alu_src_a  = SRCA_PC;
                ctrl.alu_src_b  = SRCB_FOUR;
                ctrl.result_src = RES_ALURES;
            end
            DECODE: begin
                ctrl.alu_src_a  = SRCA_PC;
                ctrl.alu_src_b  = SRCB_FOUR;
                ctrl.result_src = RES_ALURES;
            end
            MEMADR: begin
                ctrl.alu_src_b  = SRCB_EXTIMM;
            end
            MEMREAD: begin
                ctrl.mem_req    = 1'b1;
                ctrl.adr_src    = ADR_ALURES;
            end
            MEMWB: begin
                ctrl.result_src = RES_DATA;
                ctrl.reg_w      = 1'b1;
            end
            MEMWRITE: begin
                ctrl.mem_req    = 1'b1;
                ctrl.adr_src    = ADR_ALURES;
                ctrl.mem_w      = 1'b1;
            end
            EXECR: begin
                ctrl.alu_op     = 1'b1;
                ctrl.alu_src_b  = SRCB_RD2;
            end
            EXECI: begin
                ctrl.alu_op     = 1'b1;
                ctrl.alu_src_b  = SRCB_EXTIMM;
            end
            ALUWB: begin
                ctrl.reg_w      = 1'b1;
                ctrl.result_src = RES_ALUOUT;
            end
            BRANCH: begin
                ctrl.alu_src_b  = SRCB_EXTIMM;
                ctrl.result_src = RES_ALURES;
                ctrl.branch     = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Main Moore FSM of the multicycle ARM controller. Walks the shared datapath
// through fetch / decode / execute / memory / writeback and stalls on the
// memory handshake. RegW, MemW, NextPC and Branch leave here ungated; the
// downstream condition logic applies CondEx.
// Parameters:
//   CNT_W      : width of instr_count
//   WAIT_LIMIT : max cycles spent waiting on mem_ready; 0 = wait forever
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous, active-high
//   bus   : multicycle_ctrl_fsm_if.master (op/funct/mem_ready in, controls,
//           illegal_op/mem_timeout pulses, instr_count and debug state out)
// Optional build macro MC_FSM_PERF_EN: adds the retired-instruction counter;
// without it instr_count is tied to 0 and no counter flops exist.
module multicycle_ctrl_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int CNT_W      = 32,
    parameter int WAIT_LIMIT = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    multicycle_ctrl_fsm_if.master bus
);

    localparam int WAIT_W = wait_cnt_width(WAIT_LIMIT);
    // Value of the wait counter during the last allowed waiting cycle.
    localparam logic [WAIT_W-1:0] WAIT_LAST =
        WAIT_W'((WAIT_LIMIT > 0) ? WAIT_LIMIT - 1 : 0);

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              illegal_q, illegal_d;
    logic              timeout_q, timeout_d;
    ctrl_word_t        ctrl;
    logic              waiting;
    logic              timeout_hit;

    mc_state_decode u_state_decode (
        .state (state_q),
        .ctrl  (ctrl)
    );

    assign waiting = ctrl.mem_req & ~bus.mem_ready;

    // Abort on the WAIT_LIMIT-th consecutive waiting cycle. A mem_ready in
    // that cycle clears 'waiting', so a late completion still wins.
    assign timeout_hit = (WAIT_LIMIT > 0) && waiting && (wait_q == WAIT_LAST);

    // ---------------- state register ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= FETCH;
            wait_q    <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d   = state_q;
        illegal_d = 1'b0;
        case (state_q)
            FETCH:    if (bus.mem_ready) state_d = DECODE;
            DECODE: begin
                case (bus.op)
                    OP_DP:   state_d = bus.funct[5] ? EXECI : EXECR;
                    OP_MEM:  state_d = MEMADR;
                    OP_BR:   state_d = BRANCH;
                    default: begin
                        state_d   = FETCH;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            MEMADR:   state_d = bus.funct[0] ? MEMREAD : MEMWRITE;
            MEMREAD:  if (bus.mem_ready) state_d = MEMWB;
            MEMWRITE: if (bus.mem_ready) state_d = FETCH;
            EXECR:    state_d = ALUWB;
            EXECI:    state_d = ALUWB;
            ALUWB:    state_d = FETCH;
            MEMWB:    state_d = FETCH;
            BRANCH:   state_d = FETCH;
            default:  state_d = FETCH;
        endcase

        // A stalled access is abandoned and the controller refetches.
        if (timeout_hit) state_d = FETCH;

        timeout_d = timeout_hit;

        // A timeout in FETCH does not change state, so it clears explicitly.
        if (timeout_hit || (state_d != state_q)) begin
            wait_d = '0;
        end else if (waiting) begin
            wait_d = wait_q + 1'b1;
        end else begin
            wait_d = wait_q;
        end
    end

    // ---------------- output logic ----------------
    // Strobes are masked by reset itself so an access in flight is dropped
    // as soon as reset rises, not at the next clock edge.
    always_comb begin
        bus.mem_req     = ctrl.mem_req;
        bus.ir_write    = ctrl.fetch_load & bus.mem_ready;
        bus.next_pc     = ctrl.fetch_load & bus.mem_ready;
        bus.branch      = ctrl.branch;
        bus.reg_w       = ctrl.reg_w;
        bus.mem_w       = ctrl.mem_w;
        if (reset) begin
            bus.mem_req  = 1'b0;
            bus.ir_write = 1'b0;
            bus.next_pc  = 1'b0;
            bus.branch   = 1'b0;
            bus.reg_w    = 1'b0;
            bus.mem_w    = 1'b0;
        end
        bus.adr_src     = ctrl.adr_src;
        bus.alu_src_a   = ctrl.alu_src_a;
        bus.alu_src_b   = ctrl.alu_src_b;
        bus.result_src  = ctrl.result_src;
        bus.alu_op      = ctrl.alu_op;
        bus.illegal_op  = illegal_q;
        bus.mem_timeout = timeout_q;
        bus.state       = state_q;
    end

    // ---------------- retired-instruction counter ----------------
`ifdef MC_FSM_PERF_EN
    logic             retire;
    logic [CNT_W-1:0] count_q;

    // Completion points of legal instructions; a MEMWRITE abort has
    // mem_ready low and so never counts.
    assign retire = (state_q == ALUWB) || (state_q == MEMWB) ||
                    (state_q == BRANCH) ||
                    ((state_q == MEMWRITE) && bus.mem_ready);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (retire) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign bus.instr_count = count_q;
`else
    assign bus.instr_count = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
`timescale 1ns/1ps
module tb_multicycle_ctrl_fsm;

    localparam int CNT_W = 16;
    localparam int LIMIT = 4;

    // Instruction phases as the bench describes them.
    localparam int P_FETCH    = 0;
    localparam int P_DECODE   = 1;
    localparam int P_MEMADR   = 2;
    localparam int P_MEMREAD  = 3;
    localparam int P_MEMWB    = 4;
    localparam int P_MEMWRITE = 5;
    localparam int P_EXECR    = 6;
    localparam int P_EXECI    = 7;
    localparam int P_ALUWB    = 8;
    localparam int P_BRANCH   = 9;

    typedef struct {
        logic [1:0] op;
        logic [5:0] funct;
        logic       rdy;
    } stim_t;

    typedef struct {
        logic [1:0] op;
        logic [5:0] funct;
        int         len;
        int         n_regw;
        int         n_memw;
        int         n_br;
        int         n_ill;
        int         retired;
    } vec_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    multicycle_ctrl_fsm_if #(.CNT_W(CNT_W)) bus ();

    multicycle_ctrl_fsm #(.CNT_W(CNT_W), .WAIT_LIMIT(LIMIT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- scoreboard state ----------------
    stim_t       stim_q[$];
    logic [14:0] exp_q[$];
    logic        pend_ill;
    logic        pend_tmo;
    int          retired;
    int          total = 0;
    int          bad   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [14:0] obs_now();
        return {bus.mem_req, bus.ir_write, bus.next_pc, bus.branch, bus.reg_w,
                bus.mem_w, bus.adr_src, bus.alu_src_a, bus.alu_src_b,
                bus.result_src, bus.alu_op, bus.illegal_op, bus.mem_timeout};
    endfunction

    function automatic logic [14:0] mk(input logic mreq, input logic irw, input logic npc,
                                       input logic br, input logic rw, input logic mw,
                                       input logic adr, input logic sa, input logic [1:0] sb,
                                       input logic [1:0] rs, input logic aop);
        return {mreq, irw, npc, br, rw, mw, adr, sa, sb, rs, aop, 2'b00};
    endfunction

    // Expected controls for each phase, straight from the output table.
    function automatic logic [14:0] phase_obs(input int ph, input logic rdy);
        case (ph)
            P_FETCH:    return mk(1, rdy, rdy, 0, 0, 0, 0, 1, 2'b10, 2'b10, 0);
            P_DECODE:   return mk(0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b10, 0);
            P_MEMADR:   return mk(0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 0);
            P_MEMREAD:  return mk(1, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 0);
            P_MEMWB:    return mk(0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b01, 0);
            P_MEMWRITE: return mk(1, 0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 0);
            P_EXECR:    return mk(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1);
            P_EXECI:    return mk(0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 1);
            P_ALUWB:    return mk(0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 0);
            P_BRANCH:   return mk(0, 0, 0, 1, 0, 0, 0, 0, 2'b01, 2'b10, 0);
            default:    return 15'h0;
        endcase
    endfunction

    // ---------------- reference model ----------------
    // One expected cycle; pending one-cycle pulses land on the cycle after
    // their cause.
    task automatic emit(input logic [1:0] op, input logic [5:0] funct, input logic rdy, input int ph);
        stim_t s;
        s.op = op; s.funct = funct; s.rdy = rdy;
        stim_q.push_back(s);
        exp_q.push_back(phase_obs(ph, rdy) | {13'b0, pend_ill, pend_tmo});
        pend_ill = 1'b0;
        pend_tmo = 1'b0;
    endtask

    // A memory phase: d waiting cycles then completion, unless d reaches the
    // limit, in which case the access is abandoned after LIMIT waits.
    task automatic mem_phase(input logic [1:0] op, input logic [5:0] funct, input int ph,
                             input int d, output logic ok);
        if (d >= LIMIT) begin
            for (int i = 0; i < LIMIT; i++) emit(op, funct, 1'b0, ph);
            pend_tmo = 1'b1;
            ok = 1'b0;
        end else begin
            for (int i = 0; i < d; i++) emit(op, funct, 1'b0, ph);
            emit(op, funct, 1'b1, ph);
            ok = 1'b1;
        end
    endtask

    task automatic gen_instr(input logic [1:0] op, input logic [5:0] funct, input int df, input int dm);
        logic ok;
        mem_phase(op, funct, P_FETCH, df, ok);
        if (!ok) return;
        emit(op, funct, 1'b0, P_DECODE);
        case (op)
            2'b00: begin
                emit(op, funct, 1'b0, funct[5] ? P_EXECI : P_EXECR);
                emit(op, funct, 1'b0, P_ALUWB);
                retired++;
            end
            2'b01: begin
                emit(op, funct, 1'b0, P_MEMADR);
                if (funct[0]) begin
                    mem_phase(op, funct, P_MEMREAD, dm, ok);
                    if (ok) begin
                        emit(op, funct, 1'b0, P_MEMWB);
                        retired++;
                    end
                end else begin
                    mem_phase(op, funct, P_MEMWRITE, dm, ok);
                    if (ok) retired++;
                end
            end
            2'b10: begin
                emit(op, funct, 1'b0, P_BRANCH);
                retired++;
            end
            default: pend_ill = 1'b1;
        endcase
    endtask

    // ---------------- driver ----------------
    // Entered at a falling edge: apply inputs, sample 1 ns later, move on.
    task automatic run_queue(input string name);
        stim_t       s;
        logic [14:0] e;
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            e = exp_q.pop_front();
            bus.op = s.op;
            bus.funct = s.funct;
            bus.mem_ready = s.rdy;
            #1;
            check(name, {17'b0, obs_now()}, {17'b0, e});
            @(negedge clk);
        end
    endtask

    task automatic check_count(input string name);
`ifdef MC_FSM_PERF_EN
        check(name, {16'b0, bus.instr_count}, 32'(retired % (1 << CNT_W)));
`else
        check(name, {16'b0, bus.instr_count}, 32'd0);
`endif
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.mem_ready = 1'b1;
        bus.op = 2'b00;
        bus.funct = 6'b0;
        #1;
        check("reset_strobes", {24'b0, bus.mem_req, bus.ir_write, bus.next_pc, bus.branch,
                                bus.reg_w, bus.mem_w, bus.illegal_op, bus.mem_timeout}, 32'd0);
        @(negedge clk);
        #1;
        check("reset_hold", {24'b0, bus.mem_req, bus.ir_write, bus.next_pc, bus.branch,
                             bus.reg_w, bus.mem_w, bus.illegal_op, bus.mem_timeout}, 32'd0);
        check("reset_count", {16'b0, bus.instr_count}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        retired = 0;
        pend_ill = 1'b0;
        pend_tmo = 1'b0;
    endtask

    // Runs one instruction with memory always ready and summarises it: cycles
    // from its FETCH to the next FETCH, and how often each strobe fired.
    task automatic run_vec(input vec_t v);
        int   len, nrw, nmw, nbr, nill;
        logic done;
        len = 0; nrw = 0; nmw = 0; nbr = 0; nill = 0; done = 1'b0;
        bus.op = v.op;
        bus.funct = v.funct;
        bus.mem_ready = 1'b1;
        #1;
        check("tbl_fetch_irw", {31'b0, bus.ir_write}, 32'd1);
        for (int c = 1; c <= 12 && !done; c++) begin
            @(negedge clk);
            #1;
            nrw  += int'(bus.reg_w);
            nmw  += int'(bus.mem_w);
            nbr  += int'(bus.branch);
            nill += int'(bus.illegal_op);
            if (bus.ir_write) begin
                done = 1'b1;
                len = c;
            end
        end
        // Hold FETCH for a cycle so the next record starts there too.
        bus.mem_ready = 1'b0;
        check("tbl_done", {31'b0, done}, 32'd1);
        check("tbl_len", len, v.len);
        check("tbl_regw", nrw, v.n_regw);
        check("tbl_memw", nmw, v.n_memw);
        check("tbl_branch", nbr, v.n_br);
        check("tbl_illegal", nill, v.n_ill);
        retired = v.retired;
        check_count("tbl_count");
        @(negedge clk);
    endtask

    vec_t tbl[8];

    initial begin
        // op, funct, len, reg_w, mem_w, branch, illegal, cumulative retired
        tbl[0] = '{2'b00, 6'b000000, 4, 1, 0, 0, 0, 1};  // ADD reg
        tbl[1] = '{2'b00, 6'b101000, 4, 1, 0, 0, 0, 2};  // ADD imm
        tbl[2] = '{2'b00, 6'b001000, 4, 1, 0, 0, 0, 3};  // ADD reg
        tbl[3] = '{2'b10, 6'b010000, 3, 0, 0, 1, 0, 4};  // B
        tbl[4] = '{2'b11, 6'b000000, 2, 0, 0, 0, 1, 4};  // illegal
        tbl[5] = '{2'b01, 6'b011001, 5, 1, 0, 0, 0, 5};  // LDR
        tbl[6] = '{2'b01, 6'b011000, 4, 0, 1, 0, 0, 6};  // STR
        tbl[7] = '{2'b11, 6'b100001, 2, 0, 0, 0, 1, 6};  // illegal

        reset = 1'b1;
        bus.op = 2'b00;
        bus.funct = 6'b0;
        bus.mem_ready = 1'b0;
        pend_ill = 1'b0;
        pend_tmo = 1'b0;
        retired = 0;
        @(negedge clk);

        // ---- table-driven ----
        do_reset();
        for (int i = 0; i < 8; i++) run_vec(tbl[i]);

        // ---- hand sequences ----
        do_reset();
        gen_instr(2'b01, 6'b011001, 0, 3);   // LDR, three wait cycles in MEMREAD
        gen_instr(2'b01, 6'b011000, 1, 2);   // STR, mem_w held through waits
        gen_instr(2'b00, 6'b000000, 6, 0);   // FETCH timeout, IR never loaded
        gen_instr(2'b00, 6'b000000, 3, 0);   // ready in the last allowed cycle
        gen_instr(2'b01, 6'b000000, 0, 4);   // STR timeout, not retired
        gen_instr(2'b01, 6'b000001, 0, 5);   // LDR timeout, no MEMWB
        gen_instr(2'b11, 6'b111111, 0, 0);   // illegal
        emit(2'b00, 6'b0, 1'b0, P_FETCH);
        run_queue("hand");
        check_count("hand_count");

        // Reset in the middle of a FETCH after two retired ADDs.
        do_reset();
        gen_instr(2'b00, 6'b000000, 0, 0);
        gen_instr(2'b00, 6'b100000, 1, 0);
        run_queue("pre_rst");
        check_count("pre_rst_count");
        bus.mem_ready = 1'b0;
        #1;
        check("fetch_req", {31'b0, bus.mem_req}, 32'd1);
        #2 reset = 1'b1;
        #1;
        check("rst_drop_req", {31'b0, bus.mem_req}, 32'd0);
        check("rst_clr_count", {16'b0, bus.instr_count}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        retired = 0;

        // Reset while MEMREAD is stalled; the next access is a FETCH.
        emit(2'b01, 6'b000001, 1'b1, P_FETCH);
        emit(2'b01, 6'b000001, 1'b0, P_DECODE);
        emit(2'b01, 6'b000001, 1'b0, P_MEMADR);
        emit(2'b01, 6'b000001, 1'b0, P_MEMREAD);
        emit(2'b01, 6'b000001, 1'b0, P_MEMREAD);
        run_queue("ldr_stall");
        bus.mem_ready = 1'b0;
        #3 reset = 1'b1;
        #1;
        check("rst_drop_memrd", {31'b0, bus.mem_req}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        retired = 0;
        emit(2'b00, 6'b0, 1'b0, P_FETCH);
        gen_instr(2'b10, 6'b000000, 0, 0);
        emit(2'b00, 6'b0, 1'b0, P_FETCH);
        run_queue("post_rst");
        check_count("post_rst_count");

        // ---- randomized ----
        for (int b = 0; b < 4; b++) begin
            do_reset();
            for (int n = 0; n < 30; n++) begin
                gen_instr(2'($urandom_range(0, 3)), 6'($urandom_range(0, 63)),
                          $urandom_range(0, 5), $urandom_range(0, 5));
            end
            emit(2'b00, 6'b0, 1'b0, P_FETCH);
            run_queue("rand");
            check_count("rand_count");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
